// File: rtl/if_fetch_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | if_fetch_unit_if : imem request/response and decode handshake    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface if_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] pc_out;
  logic [2:0]      NPCOp;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] alu_out;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst, pc_out,
    input  imem_req_ready, imem_rsp_valid, imem_rdata, inst_ready,
           NPCOp, imm, alu_out
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst, pc_out,
    output imem_req_ready, imem_rsp_valid, imem_rdata, inst_ready,
           NPCOp, imm, alu_out
  );
endinterface
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | if_fetch_unit : PC owner, single-outstanding fetch, next-PC calc |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module if_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  if_fetch_unit_if.master  bus,
  output logic             fetch_fault,
  output logic [XLEN-1:0]  fault_addr,
  output logic [XLEN-1:0]  instret
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] pc_out_q;
  logic [XLEN-1:0] target;
  logic            consume;
  logic            capture;
  logic            aligned;

  assign consume = (state == S_HOLD) && bus.inst_ready;
  assign capture = (state == S_WAIT) && bus.imem_rsp_valid;
  assign aligned = (target[1:0] == 2'b00);

  // Request side depends only on registered state/pc, never on decode inputs.
  assign bus.imem_req_valid = (state == S_REQ);
  assign bus.imem_addr      = pc;
  assign bus.inst_valid     = (state == S_HOLD);
  assign bus.inst           = inst_q;
  assign bus.pc_out         = pc_out_q;

  always_comb begin
    target = pc + XLEN'(4);
    case (bus.NPCOp)
      3'b001,
      3'b010:  target = pc + bus.imm;
      3'b100:  target = {bus.alu_out[XLEN-1:1], 1'b0};
      default: target = pc + XLEN'(4);
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:   if (bus.imem_req_ready) state_nxt = S_WAIT;
      S_WAIT:  if (bus.imem_rsp_valid) state_nxt = S_HOLD;
      S_HOLD:  if (bus.inst_ready)     state_nxt = aligned ? S_REQ : S_FAULT;
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inst_q      <= '0;
      pc_out_q    <= '0;
      fetch_fault <= 1'b0;
      fault_addr  <= '0;
      instret     <= '0;
    end else begin
      if (capture) begin
        inst_q   <= bus.imem_rdata;
        pc_out_q <= pc;
      end
      if (consume) begin
        instret <= instret + XLEN'(1);
        // A misaligned target is latched for diagnosis; pc keeps the faulting PC.
        if (aligned) begin
          pc <= target;
        end else begin
          fetch_fault <= 1'b1;
          fault_addr  <= target;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_if_fetch_unit : directed self-checking bench for fetch stage  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_fault;
  logic [31:0] fault_addr;
  logic [31:0] instret;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_ret  = 32'd0;

  if_fetch_unit_if #(.XLEN(32)) bus ();

  if_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.master),
    .fetch_fault (fetch_fault),
    .fault_addr  (fault_addr),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Called at a negedge with the DUT in REQ; returns at the negedge after consume.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] word,
                       input logic [2:0] op, input logic [31:0] imm_v,
                       input logic [31:0] alu_v, input int stall);
    check("req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    check("req_addr", bus.imem_addr, addr);
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    check("wait_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    check("wait_no_inst", {31'd0, bus.inst_valid}, 32'd0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rdata     = word;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rdata     = 32'd0;
    check("hold_valid", {31'd0, bus.inst_valid}, 32'd1);
    check("hold_inst", bus.inst, word);
    check("hold_pc_out", bus.pc_out, addr);
    check("hold_instret", instret, exp_ret);
    for (int i = 0; i < stall; i++) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rdata     = 32'hDEAD_BEEF;
      @(negedge clk);
      check("stall_inst", bus.inst, word);
      check("stall_pc_out", bus.pc_out, addr);
      check("stall_instret", instret, exp_ret);
      check("stall_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
      check("stall_valid", {31'd0, bus.inst_valid}, 32'd1);
    end
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rdata     = 32'd0;
    bus.inst_ready     = 1'b1;
    bus.NPCOp          = op;
    bus.imm            = imm_v;
    bus.alu_out        = alu_v;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    bus.NPCOp      = 3'b000;
    exp_ret        = exp_ret + 32'd1;
    check("post_instret", instret, exp_ret);
    check("post_valid", {31'd0, bus.inst_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst                = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rdata     = 32'd0;
    bus.inst_ready     = 1'b0;
    bus.NPCOp          = 3'b000;
    bus.imm            = 32'd0;
    bus.alu_out        = 32'd0;
    repeat (2) @(negedge clk);

    check("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("rst_inst", bus.inst, 32'd0);
    check("rst_pc_out", bus.pc_out, 32'd0);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    check("rst_fault_addr", fault_addr, 32'd0);
    check("rst_instret", instret, 32'd0);
    rst = 1'b0;

    // Sequential PLUS4 stream from RESET_PC.
    for (int i = 0; i < 4; i++)
      fetch(32'(i * 4), 32'h0000_0013 + 32'(i << 8), 3'b000, 32'd0, 32'd0, 0);
    check("instret_after4", instret, 32'd4);

    // Memory back-pressure at pc=0x10.
    for (int i = 0; i < 3; i++) begin
      check("bp_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
      check("bp_req_addr", bus.imem_addr, 32'h10);
      @(negedge clk);
    end

    fetch(32'h10, 32'h0100_006F, 3'b010, 32'h10, 32'd0, 0);          // jump -> 0x20
    fetch(32'h20, 32'hFE00_08E3, 3'b001, 32'hFFFF_FFF0, 32'd0, 0);   // branch -> 0x10
    fetch(32'h10, 32'h1000_006F, 3'b010, 32'h100, 32'd0, 0);         // jump -> 0x110
    fetch(32'h110, 32'h1234_5678, 3'b011, 32'h400, 32'h800, 5);      // stall, reserved op -> 0x114
    fetch(32'h114, 32'h0000_8067, 3'b100, 32'd0, 32'h41, 0);         // jalr -> 0x40
    fetch(32'h40, 32'h0000_8067, 3'b100, 32'd0, 32'h207, 0);         // jalr -> 0x206 misaligned

    for (int i = 0; i < 3; i++) begin
      check("fault_flag", {31'd0, fetch_fault}, 32'd1);
      check("fault_addr", fault_addr, 32'h206);
      check("fault_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
      check("fault_no_inst", {31'd0, bus.inst_valid}, 32'd0);
      check("fault_instret", instret, 32'd10);
      @(negedge clk);
    end

    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    exp_ret = 32'd0;
    check("rerst_fault", {31'd0, fetch_fault}, 32'd0);
    check("rerst_fault_addr", fault_addr, 32'd0);
    check("rerst_instret", instret, 32'd0);
    check("rerst_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    check("rerst_req_addr", bus.imem_addr, 32'd0);

    // Reset while WAIT; late response must be dropped.
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    check("w_wait_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst                = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rdata     = 32'hCAFE_F00D;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rdata     = 32'd0;
    check("late_rsp_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("late_rsp_inst", bus.inst, 32'd0);

    fetch(32'h0, 32'h0050_0093, 3'b000, 32'd0, 32'd0, 0);
    check("final_req_addr", bus.imem_addr, 32'h4);
    check("final_instret", instret, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
